// File: rtl/io_strobe_sequencer.sv
// Front-panel I/O strobe sequencer: on each Enable request, walks the enabled
// peripheral strobes in slot order with per-slot polarity, fixed width and spacing.
module io_strobe_sequencer #(
  parameter int                   NUM_SLOTS  = 6,
  parameter int                   PULSE_W    = 1,
  parameter int                   GAP_W      = 1,
  parameter logic [NUM_SLOTS-1:0] ACTIVE_LOW = NUM_SLOTS'(6'b110000),
  parameter int                   SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 Clock_1us,
  input  logic                 Rst_n,
  input  logic                 Enable,
  input  logic [NUM_SLOTS-1:0] SlotMask,
  output logic [NUM_SLOTS-1:0] Strobe,
  output logic [SLOT_W-1:0]    Slot,
  output logic                 Busy,
  output logic                 Done
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_HOLD} state_t;

  localparam logic [7:0] PW_LAST  = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_W - 1);

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_cnt, w_cnt_nxt;
  logic [NUM_SLOTS-1:0]   r_mask, w_mask_nxt;
  logic [SLOT_W-1:0]      r_slot, w_slot_nxt;
  logic [NUM_SLOTS-1:0]   r_strobe, w_strobe_nxt;
  logic                   r_busy, r_done, w_done_nxt, w_fire;
  logic [SLOT_W:0]        w_first, w_after;

  // Lowest set slot in m, either anywhere or strictly above cur; MSB flags a hit.
  function automatic logic [SLOT_W:0] find_slot(input logic [NUM_SLOTS-1:0] m,
                                                input logic [SLOT_W-1:0]    cur,
                                                input logic                 from_start);
    logic [SLOT_W:0] r;
    r = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i] && (from_start || (i > int'(cur)))) r = {1'b1, SLOT_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_slot_nxt  = r_slot;
    w_fire      = 1'b0;
    w_done_nxt  = 1'b0;
    w_first     = find_slot(SlotMask, '0, 1'b1);
    w_after     = find_slot(r_mask, r_slot, 1'b0);
    case (r_state)
      S_IDLE: begin
        if (Enable) begin
          w_mask_nxt = SlotMask;
          w_cnt_nxt  = '0;
          if (w_first[SLOT_W]) begin
            w_state_nxt = S_PULSE;
            w_slot_nxt  = w_first[SLOT_W-1:0];
            w_fire      = 1'b1;
          end else begin
            w_state_nxt = S_HOLD;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_PULSE: begin
        if (r_cnt == PW_LAST) begin
          w_cnt_nxt = '0;
          // A dropped request still lets the running pulse finish its full width.
          if (!Enable) begin
            w_state_nxt = S_IDLE;
          end else if (w_after[SLOT_W]) begin
            if (GAP_W > 0) begin
              w_state_nxt = S_GAP;
            end else begin
              w_slot_nxt = w_after[SLOT_W-1:0];
              w_fire     = 1'b1;
            end
          end else begin
            w_state_nxt = S_HOLD;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          w_fire    = 1'b1;
        end
      end
      S_GAP: begin
        if (!Enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_PULSE;
          w_slot_nxt  = w_after[SLOT_W-1:0];
          w_fire      = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (!Enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_strobe_nxt = ACTIVE_LOW ^ (w_fire ? (NUM_SLOTS'(1) << w_slot_nxt) : '0);
  end

  always_ff @(posedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_slot   <= '0;
      r_strobe <= ACTIVE_LOW;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_slot   <= w_slot_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= (w_state_nxt == S_PULSE) || (w_state_nxt == S_GAP);
      r_done   <= w_done_nxt;
    end
  end

  assign Strobe = r_strobe;
  assign Slot   = r_slot;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule

// File: tb/tb_io_strobe_sequencer.sv
// Bench for io_strobe_sequencer: three parameterisations share one stimulus stream
// and are checked against a timing-formula reference model.
module tb_io_strobe_sequencer;

  localparam logic [5:0] AL = 6'b110000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [5:0] mask = '0;
  logic [5:0] strobe_o [3];
  logic [2:0] slot_o   [3];
  logic       busy_o   [3];
  logic       done_o   [3];

  int total = 0;
  int bad   = 0;
  int pw [3] = '{1, 3, 4};
  int gw [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  io_strobe_sequencer #(.NUM_SLOTS(6), .PULSE_W(1), .GAP_W(1), .ACTIVE_LOW(AL)) u_a (
    .Clock_1us(clk), .Rst_n(rst_n), .Enable(en), .SlotMask(mask),
    .Strobe(strobe_o[0]), .Slot(slot_o[0]), .Busy(busy_o[0]), .Done(done_o[0]));
  io_strobe_sequencer #(.NUM_SLOTS(6), .PULSE_W(3), .GAP_W(0), .ACTIVE_LOW(AL)) u_b (
    .Clock_1us(clk), .Rst_n(rst_n), .Enable(en), .SlotMask(mask),
    .Strobe(strobe_o[1]), .Slot(slot_o[1]), .Busy(busy_o[1]), .Done(done_o[1]));
  io_strobe_sequencer #(.NUM_SLOTS(6), .PULSE_W(4), .GAP_W(1), .ACTIVE_LOW(AL)) u_c (
    .Clock_1us(clk), .Rst_n(rst_n), .Enable(en), .SlotMask(mask),
    .Strobe(strobe_o[2]), .Slot(slot_o[2]), .Busy(busy_o[2]), .Done(done_o[2]));

  typedef struct {
    logic       en;
    logic [5:0] mask;
    logic [5:0] strobe;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Expected outputs in cycle c of a sequence started by Enable sampled at edge 1.
  function automatic void model(input int p, input int g, input logic [5:0] m, input int c,
                                output int act, output logic busy, output logic done);
    int n;
    int lst [6];
    int len;
    n = 0;
    for (int i = 0; i < 6; i++) if (m[i]) begin lst[n] = i; n++; end
    len = (n == 0) ? 0 : n * p + (n - 1) * g;
    act = -1;
    busy = 1'b0;
    done = (c == len + 1);
    if (c >= 1 && c <= len) begin
      busy = 1'b1;
      if (((c - 1) % (p + g)) < p) act = lst[(c - 1) / (p + g)];
    end
  endfunction

  // One full sequence with Enable held high; SlotMask scrambled after the start edge.
  task automatic run_seq(input logic [5:0] m, input string tag);
    int   len, act;
    logic eb, ed;
    len = 6 * 4 + 5 + 3;
    for (int c = 1; c <= len; c++) begin
      en = 1'b1;
      mask = (c == 1) ? m : 6'($urandom_range(0, 63));
      tick();
      for (int k = 0; k < 3; k++) begin
        model(pw[k], gw[k], m, c, act, eb, ed);
        chk($sformatf("%s u%0d c%0d strobe", tag, k, c), 32'(strobe_o[k]),
            32'(AL ^ ((act >= 0) ? (6'd1 << act) : 6'd0)));
        chk($sformatf("%s u%0d c%0d busy", tag, k, c), 32'(busy_o[k]), 32'(eb));
        chk($sformatf("%s u%0d c%0d done", tag, k, c), 32'(done_o[k]), 32'(ed));
        if (act >= 0) chk($sformatf("%s u%0d c%0d slot", tag, k, c), 32'(slot_o[k]), 32'(act));
      end
    end
    en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 6'h3F, 6'b110001, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 6'h00, 6'b110000, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 6'h00, 6'b110010, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 6'h00, 6'b110000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 6'h00, 6'b110100, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 6'h00, 6'b110000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 6'h00, 6'b111000, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 6'h00, 6'b110000, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 6'h00, 6'b100000, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 6'h00, 6'b110000, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 6'h00, 6'b010000, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 6'h00, 6'b110000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 6'h00, 6'b110000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 6'h00, 6'b110000, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset u%0d strobe", k), 32'(strobe_o[k]), 32'(AL));
      chk($sformatf("reset u%0d slot", k), 32'(slot_o[k]), 32'd0);
      chk($sformatf("reset u%0d busy", k), 32'(busy_o[k]), 32'd0);
      chk($sformatf("reset u%0d done", k), 32'(done_o[k]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Full default sequence, mask cleared after start must be ignored
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      mask = tbl[i].mask;
      tick();
      chk($sformatf("tbl c%0d strobe", i + 1), 32'(strobe_o[0]), 32'(tbl[i].strobe));
      chk($sformatf("tbl c%0d busy", i + 1), 32'(busy_o[0]), 32'(tbl[i].busy));
      chk($sformatf("tbl c%0d done", i + 1), 32'(done_o[0]), 32'(tbl[i].done));
    end

    do_reset();
    run_seq(6'b100101, "sparse");
    run_seq(6'b000000, "empty");
    run_seq(6'b111111, "full");

    // Enable dropped during slot 2 of the PULSE_W=4 instance
    do_reset();
    en = 1'b1;
    mask = 6'h3F;
    for (int c = 1; c <= 22; c++) begin
      if (c == 13) en = 1'b0;
      tick();
      chk($sformatf("abort c%0d strobe", c), 32'(strobe_o[2]),
          32'((c >= 11 && c <= 14) ? 6'b110100 : (c >= 6 && c <= 9) ? 6'b110010 :
              (c <= 4) ? 6'b110001 : AL));
      chk($sformatf("abort c%0d done", c), 32'(done_o[2]), 32'd0);
      if (c >= 15) chk($sformatf("abort c%0d busy", c), 32'(busy_o[2]), 32'd0);
    end

    // Async reset in the middle of slot 4 (active-low strobe)
    do_reset();
    en = 1'b1;
    mask = 6'h3F;
    for (int c = 1; c <= 9; c++) tick();
    chk("pol slot4 strobe", 32'(strobe_o[0]), 32'(6'b100000));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst strobe", 32'(strobe_o[0]), 32'(AL));
    chk("async rst busy", 32'(busy_o[0]), 32'd0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Enable held high after Done must not retrigger
    en = 1'b1;
    for (int c = 1; c <= 12; c++) tick();
    chk("hold done", 32'(done_o[0]), 32'd1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("hold c%0d strobe", c), 32'(strobe_o[0]), 32'(AL));
      chk($sformatf("hold c%0d busy", c), 32'(busy_o[0]), 32'd0);
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("restart strobe", 32'(strobe_o[0]), 32'(6'b110001));
    chk("restart busy", 32'(busy_o[0]), 32'd1);
    en = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    // Randomized masks against the reference model
    do_reset();
    for (int r = 0; r < 30; r++) run_seq(6'($urandom_range(0, 63)), $sformatf("rnd%0d", r));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
